// File: rtl/ldst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ldst_mem_ctrl
// Purpose  : Load/store sequencer between the EX/MEM pipeline register and a
//            multi-cycle, ack-handshaked 16-bit data memory. Recognises LW
//            (opcode 4'b1000) and SW (opcode 4'b1001), issues a single-cycle
//            memory request, stalls the pipeline while the access is
//            outstanding, returns load data with a one-cycle valid pulse and
//            aborts an access whose ack does not arrive in time.
//
// Ports    : clk        in   system clock, rising edge
//            rst        in   asynchronous active-high reset
//            ex_valid   in   EX/MEM holds a valid instruction
//            ex_opcode  in   [3:0]  inst[15:12]
//            ex_addr    in   [15:0] effective address
//            ex_wdata   in   [15:0] store data
//            mem_req    out  request strobe (one cycle per access)
//            mem_we     out  1 = write, 0 = read; valid while mem_req
//            mem_addr   out  [15:0] latched address
//            mem_wdata  out  [15:0] latched store data
//            mem_rdata  in   [15:0] read data, sampled with mem_ack
//            mem_ack    in   memory completion strobe
//            stall      out  freeze IF/ID/EX and EX/MEM
//            ld_data    out  [15:0] registered load result
//            ld_valid   out  one-cycle pulse, ld_data valid (LW only)
//            timeout    out  one-cycle pulse, access aborted
//            misalign   out  one-cycle pulse, odd address rejected
//
// Params   : TIMEOUT  maximum WAIT cycles before abort (1 .. 2**CNT_W-1)
//            CNT_W    width of the wait counter
//
// Config   : `define ALIGN_CHECK_EN  -> odd addresses are rejected in IDLE
//            (no memory request, misalign pulse). Left undefined, misalign
//            is tied low and odd addresses are issued unchanged.
//
// Revision : 1.0  initial release
// ============================================================================
module ldst_mem_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [15:0] ld_data,
  output logic        ld_valid,
  output logic        timeout,
  output logic        misalign
);

  localparam logic [3:0]       c_op_lw   = 4'b1000;
  localparam logic [3:0]       c_op_sw   = 4'b1001;
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_we;
  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic [15:0]      r_ld_data;
  logic             r_ld_valid;
  logic             r_timeout;
  logic             r_misalign;
  logic [CNT_W-1:0] r_cnt;

  logic             w_mem_op;
  logic             w_odd;
  logic             w_cnt_hit;
  logic             w_stall;
  logic             w_req;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  assign w_mem_op = ex_valid & ((ex_opcode == c_op_lw) | (ex_opcode == c_op_sw));

`ifdef ALIGN_CHECK_EN
  assign w_odd = ex_addr[0];
`else
  assign w_odd = 1'b0;
`endif

  // The counter holds the number of WAIT cycles entered so far (1 in the
  // first WAIT cycle), so hitting TIMEOUT means this is the last WAIT cycle.
  assign w_cnt_hit = (r_cnt == c_timeout);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // ack arriving here belongs to nothing and is ignored
        if (w_mem_op) begin
          w_stall     = 1'b1;
          w_state_nxt = w_odd ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_stall     = 1'b1;
        w_req       = 1'b1;
        w_state_nxt = mem_ack ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (mem_ack || w_cnt_hit) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // stall low: the pipeline advances during this cycle
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: latched request fields, wait counter, result pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= 16'h0000;
      r_wdata    <= 16'h0000;
      r_ld_data  <= 16'h0000;
      r_ld_valid <= 1'b0;
      r_timeout  <= 1'b0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // pulses are only ever set on the transition into DONE
      r_ld_valid <= 1'b0;
      r_timeout  <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_cnt <= '0;
            if (w_odd) begin
              r_misalign <= 1'b1;
            end else begin
              r_addr  <= ex_addr;
              r_wdata <= ex_wdata;
              r_we    <= (ex_opcode == c_op_sw);
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (mem_ack) begin
            // ack has priority over an expiring counter
            if (!r_we) begin
              r_ld_data  <= mem_rdata;
              r_ld_valid <= 1'b1;
            end
          end else if ((r_state == S_WAIT) && w_cnt_hit) begin
            r_ld_data <= 16'h0000;
            r_timeout <= 1'b1;
          end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req   = w_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  // A held EX/MEM instruction must not raise stall while reset is applied.
  assign stall     = w_stall & ~rst;
  assign ld_data   = r_ld_data;
  assign ld_valid  = r_ld_valid;
  assign timeout   = r_timeout;
  assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_ldst_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ldst_mem_ctrl
// Purpose  : Self-checking bench for ldst_mem_ctrl. The bench plays the data
//            memory (a small array), answers each request after a chosen
//            number of cycles and predicts latency, stall length, pulses and
//            load data from the access rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_ldst_mem_ctrl;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int LIMIT   = TIMEOUT + 10;

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_addr;
  logic [15:0] ex_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [15:0] ld_data;
  logic        ld_valid;
  logic        timeout;
  logic        misalign;

  always #5 clk = ~clk;

  ldst_mem_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_opcode (ex_opcode),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .timeout   (timeout),
    .misalign  (misalign)
  );

  int checks   = 0;
  int failures = 0;

  // bench memory and expected load-result register
  logic [15:0] mem_model [0:7];
  logic [15:0] exp_ld;

  // --------------------------------------------------------------------------
  // One access. Entered and left at posedge+1; leaves ex_valid asserted so the
  // caller can chain another op back-to-back or go idle. d = cycles from the
  // request to the ack (0 = ack with the request); d > TIMEOUT = never ack.
  // --------------------------------------------------------------------------
  task automatic do_op(input string name, input bit is_sw, input logic [15:0] addr,
                       input logic [15:0] wdata, input int d);
    int c, req_c, nreq, nstall, ev_c, npulse, exp_stall, exp_req, exp_pulse;
    bit done, mis, ok, tmo, we_bad, addr_bad, wd_bad, lv_ev, to_ev, mis_ev;
    logic [15:0] ld_ev;
    mis = ALIGN_EN && addr[0];
    ok  = !mis && (d <= TIMEOUT);
    tmo = !mis && (d >  TIMEOUT);
    exp_req   = mis ? 0 : 1;
    exp_stall = mis ? 1 : (ok ? 2 + d : 2 + TIMEOUT);
    exp_pulse = (mis || tmo || (ok && !is_sw)) ? 1 : 0;
    ex_valid  = 1'b1;
    ex_opcode = is_sw ? 4'b1001 : 4'b1000;
    ex_addr   = addr;
    ex_wdata  = wdata;
    c = 0; req_c = -1; nreq = 0; nstall = 0; ev_c = -1; npulse = 0;
    done = 0; we_bad = 0; addr_bad = 0; wd_bad = 0;
    lv_ev = 0; to_ev = 0; mis_ev = 0; ld_ev = 16'h0000;
    while (!done && c < LIMIT) begin
      if (mem_req === 1'b1 && req_c < 0) req_c = c;
      mem_ack   = (req_c >= 0) && (d <= TIMEOUT) && (c == req_c + d);
      mem_rdata = mem_ack ? mem_model[addr[3:1]] : 16'($urandom);
      @(negedge clk);
      if (stall === 1'b1) nstall++;
      if (mem_req === 1'b1) begin
        nreq++;
        if (mem_we !== is_sw) we_bad = 1;
        if (mem_addr !== addr) addr_bad = 1;
        if (is_sw && mem_wdata !== wdata) wd_bad = 1;
      end
      if (ld_valid === 1'b1 || timeout === 1'b1 || misalign === 1'b1) npulse++;
      if (stall !== 1'b1 && c > 0) begin
        done = 1; ev_c = c;
        lv_ev = ld_valid; to_ev = timeout; mis_ev = misalign; ld_ev = ld_data;
      end
      @(posedge clk); #1;
      c++;
    end
    mem_ack = 1'b0;
    // reference model update
    if (ok && is_sw) mem_model[addr[3:1]] = wdata;
    if (ok && !is_sw) exp_ld = mem_model[addr[3:1]];
    if (tmo) exp_ld = 16'h0000;

    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s done_reached: got 0 within %0d cycles, want 1", name, LIMIT);
    end
    checks++;
    if (nstall != exp_stall) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, nstall, exp_stall);
    end
    checks++;
    if (ev_c != exp_stall) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, ev_c, exp_stall);
    end
    checks++;
    if (nreq != exp_req) begin
      failures++;
      $display("FAIL %s req_count: got %0d want %0d", name, nreq, exp_req);
    end
    if (exp_req == 1) begin
      checks++;
      if (req_c != 1) begin
        failures++;
        $display("FAIL %s req_cycle: got %0d want 1", name, req_c);
      end
      checks++;
      if (we_bad || addr_bad || wd_bad) begin
        failures++;
        $display("FAIL %s req_fields: got we_bad=%0d addr_bad=%0d wdata_bad=%0d want 0/0/0",
                 name, we_bad, addr_bad, wd_bad);
      end
    end
    checks++;
    if (lv_ev !== (ok && !is_sw) || to_ev !== tmo || mis_ev !== mis) begin
      failures++;
      $display("FAIL %s done_pulses: got lv=%0b to=%0b mis=%0b want lv=%0b to=%0b mis=%0b",
               name, lv_ev, to_ev, mis_ev, (ok && !is_sw), tmo, mis);
    end
    checks++;
    if (npulse != exp_pulse) begin
      failures++;
      $display("FAIL %s pulse_count: got %0d want %0d", name, npulse, exp_pulse);
    end
    checks++;
    if (ld_ev !== exp_ld) begin
      failures++;
      $display("FAIL %s ld_data: got %h want %h", name, ld_ev, exp_ld);
    end
  endtask

  // idle cycles with ex_valid low: nothing may move
  task automatic idle(input string name, input int n);
    ex_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || ld_valid !== 1'b0 || timeout !== 1'b0 ||
          misalign !== 1'b0 || ld_data !== exp_ld) begin
        failures++;
        $display("FAIL %s idle: got stall=%b req=%b lv=%b to=%b mis=%b ld=%h want 0/0/0/0/0 ld=%h",
                 name, stall, mem_req, ld_valid, timeout, misalign, ld_data, exp_ld);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0 ||
        stall !== 1'b0 || ld_data !== 16'h0 || ld_valid !== 1'b0 || timeout !== 1'b0 ||
        misalign !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs: got req=%b we=%b addr=%h wd=%h stall=%b ld=%h lv=%b to=%b mis=%b want all 0",
               name, mem_req, mem_we, mem_addr, mem_wdata, stall, ld_data, ld_valid, timeout, misalign);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = 4'h0; ex_addr = 16'h0; ex_wdata = 16'h0;
    mem_ack = 1'b0; mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    exp_ld = 16'h0000;
    @(posedge clk); #1;
    idle("post_reset", 2);
  endtask

  task automatic test_lw_basic();
    mem_model[3'(16'h0010 >> 1)] = 16'hBEEF;
    do_op("lw_basic", 1'b0, 16'h0010, 16'h0000, 1);
    checks++;
    if (ld_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL lw_basic beef: got %h want beef", ld_data);
    end
    idle("lw_basic", 2);
  endtask

  task automatic test_sw_basic();
    do_op("sw_basic", 1'b1, 16'h0020, 16'h1234, 0);
    idle("sw_basic", 1);
    // read it back through the controller
    do_op("sw_readback", 1'b0, 16'h0020, 16'h0000, 2);
    idle("sw_readback", 1);
  endtask

  task automatic test_timeout();
    do_op("timeout", 1'b0, 16'h0006, 16'h0000, TIMEOUT + 1);
    idle("timeout", 2);
  endtask

  task automatic test_ack_at_limit();
    do_op("ack_at_limit", 1'b0, 16'h0008, 16'h0000, TIMEOUT);
    idle("ack_at_limit", 1);
    do_op("ack_before_limit", 1'b0, 16'h000A, 16'h0000, TIMEOUT - 1);
    idle("ack_before_limit", 1);
  endtask

  task automatic test_nonmem();
    ex_valid = 1'b1; ex_opcode = 4'b0011; ex_addr = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      ex_opcode = 4'($urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL nonmem: got stall=%b req=%b want 0/0", stall, mem_req);
      end
      @(posedge clk); #1;
    end
    idle("nonmem", 1);
  endtask

  task automatic test_reset_mid_access();
    ex_valid = 1'b1; ex_opcode = 4'b1000; ex_addr = 16'h000C; mem_ack = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid in_wait: got stall=%b want 1", stall);
    end
    #2 rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_ld = 16'h0000;
    @(posedge clk); #1;
    // a late ack in IDLE must be ignored
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || ld_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid late_ack: got stall=%b req=%b lv=%b want 0/0/0", stall, mem_req, ld_valid);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    idle("reset_mid", 2);
  endtask

  task automatic test_align();
    do_op("align_lw_odd", 1'b0, 16'h0011, 16'h0000, 1);
    idle("align", 1);
    do_op("align_sw_odd", 1'b1, 16'h0013, 16'h5A5A, 0);
    idle("align", 1);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_0", 1'b1, 16'h0002, 16'hA1A1, 0);
    do_op("b2b_1", 1'b0, 16'h0002, 16'h0000, 0);
    do_op("b2b_2", 1'b1, 16'h0004, 16'hB2B2, 3);
    do_op("b2b_3", 1'b0, 16'h0004, 16'h0000, 1);
    do_op("b2b_4", 1'b0, 16'h0002, 16'h0000, TIMEOUT + 1);
    idle("b2b", 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit          sw;
      logic [15:0] a;
      int          d;
      sw = 1'($urandom);
      a  = {12'($urandom), 3'($urandom), 1'b0};
      d  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3)
                                      : $urandom_range(TIMEOUT - 1, TIMEOUT + 1);
      do_op("random", sw, a, 16'($urandom), d);
      if ($urandom_range(0, 2) != 0) idle("random", $urandom_range(1, 2));
    end
    idle("random_end", 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_model[i] = 16'(i * 16'h1111);
    exp_ld = 16'h0000;
    test_reset();
    test_lw_basic();
    test_sw_basic();
    test_timeout();
    test_ack_at_limit();
    test_nonmem();
    test_reset_mid_access();
    test_align();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
